alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_fifo.sv | 58 +++++
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU op sequencer.
// The optional sticky-flag feature is selected in the top with ALU_SEQ_STICKY_FLAGS_EN.
package alu_seq_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 4;

  // Bit positions inside the packed {Z,C,V,P} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: power-of-two command FIFO with combinational head data.
// Pointers wrap naturally at DEPTH; the count spans 0..DEPTH.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; a same-edge push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues commands, issues them one at a time to an external ALU, returns results.
// Define ALU_SEQ_STICKY_FLAGS_EN to add the sticky_clr / sticky_flags accumulator.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [OP_W-1:0] cmd_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    alu_out,
  input  logic [3:0]      alu_flags,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic [3:0]      res_flags,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic            sticky_clr,
  output logic [3:0]      sticky_flags,
`endif
  output logic            busy
);

  localparam int CMD_W = 2 * W + OP_W;

  state_t          state_r;
  state_t          next_s;
  logic            load_s;
  logic            capture_s;
  logic            busy_s;
  logic            push_s;
  logic            full_s;
  logic            empty_s;
  logic [CMD_W-1:0] head_s;
  logic [3:0]      flags_s;

  logic [W-1:0]    alu_a_r;
  logic [W-1:0]    alu_b_r;
  logic [OP_W-1:0] alu_op_r;
  logic            res_valid_r;
  logic [W-1:0]    res_data_r;
  logic [3:0]      res_flags_r;

  assign push_s    = cmd_valid && cmd_ready;
  assign cmd_ready = !full_s;
  assign flags_s   = {alu_flags[FLAG_Z], alu_flags[FLAG_C], alu_flags[FLAG_V], alu_flags[FLAG_P]};

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (load_s),
    .wdata ({cmd_a, cmd_b, cmd_op}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state; load pops the FIFO head into the ALU drive registers
  always_comb begin
    next_s    = state_r;
    load_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          next_s = ST_ISSUE;
          load_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        next_s    = ST_HOLD;
        capture_s = 1'b1;
      end
      ST_HOLD: begin
        if (res_ready && !empty_s) begin
          next_s = ST_ISSUE;
          load_s = 1'b1;
        end else if (res_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_HOLD;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // FSM-derived status output
  always_comb begin
    busy_s = (state_r != ST_IDLE) || !empty_s;
  end

  // ALU drive and result capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_op_r    <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_flags_r <= 4'b0000;
    end else begin
      if (load_s) begin
        alu_a_r  <= head_s[CMD_W-1 -: W];
        alu_b_r  <= head_s[OP_W +: W];
        alu_op_r <= head_s[OP_W-1:0];
      end
      if (capture_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= alu_out;
        res_flags_r <= flags_s;
      end else if (state_r == ST_HOLD && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic [3:0] sticky_r;

  // Sticky accumulator; a clear wins over a same-edge capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 4'b0000;
    end else if (sticky_clr) begin
      sticky_r <= 4'b0000;
    end else if (capture_s) begin
      sticky_r <= sticky_r | flags_s;
    end
  end

  assign sticky_flags = sticky_r;
`endif

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_flags = res_flags_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with a behavioural ALU stub and hand-computed results.
// Sticky-flag checks compile only when ALU_SEQ_STICKY_FLAGS_EN is defined.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [3:0] alu_out;
  logic [3:0] alu_flags;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_flags;
  logic       busy;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic [3:0] sticky_flags;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] d;
    logic [3:0] f;
    int         c;
  } res_t;
  res_t res_q[$];

  logic [3:0] exp_d [16];
  logic [3:0] exp_f [16];

  alu_op_sequencer #(.DEPTH(4), .W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU returning {Z,C,V,P, out}
  function automatic logic [7:0] alu_stub(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [4:0] wide;
    logic [3:0] o;
    logic       c;
    logic       v;
    wide = 5'd0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      4'd0:  begin wide = {1'b0, a} + {1'b0, b}; o = wide[3:0]; c = wide[4]; v = (a[3] == b[3]) && (o[3] != a[3]); end
      4'd1:  begin wide = {1'b0, a} - {1'b0, b}; o = wide[3:0]; c = wide[4]; v = (a[3] != b[3]) && (o[3] != a[3]); end
      4'd2:  o = a & b;
      4'd3:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  o = ~a;
      4'd6:  o = a;
      4'd7:  o = b;
      4'd8:  o = a << 1;
      4'd9:  o = a >> 1;
      4'd10: o = a + 4'd1;
      4'd11: o = a - 4'd1;
      4'd12: o = 4'd0;
      4'd13: o = ~(a & b);
      4'd14: o = ~(a | b);
      default: o = ~(a ^ b);
    endcase
    return {(o == 4'd0), c, v, ^o, o};
  endfunction

  assign {alu_flags, alu_out} = alu_stub(alu_a, alu_b, alu_op);

  // Result monitor: records each handshake just before the edge that completes it
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      res_q.push_back('{res_data, res_flags, cyc});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int g = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && g < 50) begin
      tick();
      g++;
    end
    if (!cmd_ready) check_eq("push_timeout", cmd_ready, 1'b1);
    tick();
  endtask

  task automatic wait_results(input int n);
    int g = 0;
    while (res_q.size() < n && g < 300) begin
      tick();
      g++;
    end
    check_eq("n_results", res_q.size(), n);
  endtask

  task automatic check_results(input string tag, input int n, input bit spacing);
    for (int i = 0; i < n && i < res_q.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), res_q[i].d, exp_d[i]);
      check_eq($sformatf("%s_flags%0d", tag, i), res_q[i].f, exp_f[i]);
      if (spacing && i > 0) check_eq($sformatf("%s_gap%0d", tag, i), res_q[i].c - res_q[i-1].c, 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    cmd_op    = 4'd0;
    res_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_alu", {alu_a, alu_b, alu_op}, 12'h000);
    check_eq("rst_res", {res_data, res_flags}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // Single command latency
    push(4'h5, 4'hC, 4'h0);
    cmd_valid = 1'b0;
    check_eq("lat_e0_valid", res_valid, 1'b0);
    check_eq("lat_e0_busy", busy, 1'b1);
    tick();
    check_eq("lat_e1_alu", {alu_a, alu_b, alu_op}, 12'h5C0);
    check_eq("lat_e1_valid", res_valid, 1'b0);
    tick();
    check_eq("lat_e2_valid", res_valid, 1'b1);
    check_eq("lat_e2_data", res_data, 4'h1);
    check_eq("lat_e2_flags", res_flags, 4'b0101);
    tick();
    check_eq("hold_valid", res_valid, 1'b1);
    check_eq("hold_data", res_data, 4'h1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("done_valid", res_valid, 1'b0);
    check_eq("done_busy", busy, 1'b0);
    check_eq("idle_alu_hold", {alu_a, alu_b, alu_op}, 12'h5C0);

    // Opcode sweep at full rate
    res_q.delete();
    exp_d = '{4'h1, 4'h9, 4'h4, 4'hD, 4'h9, 4'hA, 4'h5, 4'hC, 4'hA, 4'h2, 4'h6, 4'h4, 4'h0, 4'hB, 4'h2, 4'h6};
    exp_f = '{4'h5, 4'h6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h8, 4'h1, 4'h1, 4'h0};
    res_ready = 1'b1;
    for (int op = 0; op < 16; op++) push(4'h5, 4'hC, 4'(op));
    cmd_valid = 1'b0;
    wait_results(16);
    check_results("sweep", 16, 1'b1);
    tick();
    res_ready = 1'b0;

    // Backpressure until the FIFO is full
    res_q.delete();
    push(4'h5, 4'hC, 4'd6);
    push(4'h5, 4'hC, 4'd7);
    push(4'h5, 4'hC, 4'd9);
    push(4'h5, 4'hC, 4'd10);
    push(4'h5, 4'hC, 4'd11);
    check_eq("bp_full", cmd_ready, 1'b0);
    check_eq("bp_valid", res_valid, 1'b1);
    check_eq("bp_data", res_data, 4'h5);
    cmd_a  = 4'h5;
    cmd_b  = 4'hC;
    cmd_op = 4'd12;
    tick();
    tick();
    tick();
    check_eq("bp_stall", cmd_ready, 1'b0);
    check_eq("bp_stable", res_data, 4'h5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("bp_pop_ready", cmd_ready, 1'b1);
    check_eq("bp_pop_valid", res_valid, 1'b0);
    tick();
    check_eq("bp_refull", cmd_ready, 1'b0);
    check_eq("bp_next_valid", res_valid, 1'b1);
    check_eq("bp_next_data", res_data, 4'hC);
    cmd_valid = 1'b0;
    exp_d[0:5] = '{4'h5, 4'hC, 4'h2, 4'h6, 4'h4, 4'h0};
    exp_f[0:5] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h8};
    res_ready = 1'b1;
    wait_results(6);
    check_results("bp", 6, 1'b0);
    tick();
    res_ready = 1'b0;

    // Simultaneous push and pop, ordering across pointer wrap
    res_q.delete();
    push(4'd1, 4'd0, 4'd6);
    push(4'd2, 4'd0, 4'd6);
    push(4'd3, 4'd0, 4'd6);
    res_ready = 1'b1;
    push(4'd4, 4'd0, 4'd6);
    res_ready = 1'b0;
    push(4'd5, 4'd0, 4'd6);
    check_eq("pp_count3", cmd_ready, 1'b1);
    push(4'd6, 4'd0, 4'd6);
    check_eq("pp_count4", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    exp_d[0:5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    exp_f[0:5] = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    res_ready = 1'b1;
    wait_results(6);
    check_results("pp", 6, 1'b0);
    tick();
    res_ready = 1'b0;

    // Reset while holding a result with entries queued
    res_q.delete();
    for (int i = 0; i < 4; i++) push(4'h5, 4'hC, 4'h0);
    cmd_valid = 1'b0;
    check_eq("mr_pre_valid", res_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", res_valid, 1'b0);
    check_eq("mr_ready", cmd_ready, 1'b1);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_alu", {alu_a, alu_b, alu_op}, 12'h000);
    check_eq("mr_res", {res_data, res_flags}, 8'h00);
    tick();
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (10) tick();
    check_eq("mr_no_result", res_q.size(), 0);
    check_eq("mr_post_valid", res_valid, 1'b0);
    check_eq("mr_post_busy", busy, 1'b0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // Sticky flag accumulation and clear priority
    res_q.delete();
    check_eq("st_reset", sticky_flags, 4'b0000);
    push(4'h5, 4'hC, 4'd12);
    push(4'h7, 4'h5, 4'd0);
    cmd_valid = 1'b0;
    wait_results(2);
    tick();
    check_eq("st_or", sticky_flags, 4'b1010);
    push(4'h5, 4'hC, 4'd0);
    cmd_valid = 1'b0;
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check_eq("st_clr_prio", sticky_flags, 4'b0000);
    check_eq("st_cap_flags", res_flags, 4'b0101);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
